// File: rtl/mem_access_pkg.sv
// mem_access_pkg: funct3 encodings, FSM state type and byte-lane masks for mem_access_unit
package mem_access_pkg;
  typedef logic [2:0] f3_t;
  localparam f3_t F3_B  = 3'b000;
  localparam f3_t F3_H  = 3'b001;
  localparam f3_t F3_W  = 3'b010;
  localparam f3_t F3_BU = 3'b100;
  localparam f3_t F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, LOAD, RMW_READ, WRITE} state_t;
  localparam logic [31:0] LANE_B = 32'h0000_00FF;
  localparam logic [31:0] LANE_H = 32'h0000_FFFF;
  localparam logic [31:0] LANE_W = 32'hFFFF_FFFF;
endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: req/ready/done load-store request bus between controller and mem_access_unit
interface mem_access_if;
  import mem_access_pkg::*;
  logic req, we, ready, done, err;
  f3_t funct3;
  logic [31:0] addr, wdata, rdata;
  modport master(output req, we, funct3, addr, wdata, input ready, done, rdata, err);
  modport slave(input req, we, funct3, addr, wdata, output ready, done, rdata, err);
endinterface

// File: rtl/mem_lane_merge.sv
// mem_lane_merge: byte/half extract with sign/zero extension for loads and byte-lane merge for stores
module mem_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  ofs,
  input  f3_t         f3,
  output logic [31:0] ld,
  output logic [31:0] st
);
  logic [4:0] sh;
  logic [31:0] w_sh, mask;
  always_comb begin
    sh = {ofs, 3'b000};
    w_sh = word >> sh;
    mask = (f3[1] ? LANE_W : f3[0] ? LANE_H : LANE_B) << sh;
    ld = f3[1] ? w_sh
       : f3[0] ? {{16{~f3[2] & w_sh[15]}}, w_sh[15:0]}
       : {{24{~f3[2] & w_sh[7]}}, w_sh[7:0]};
    st = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: sub-word load/store front-end with RMW stores; MEM_ACCESS_MISALIGN_CHECK_EN rejects misaligned accesses
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  mem_access_if.slave     bus,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_wren,
  input  logic [XLEN-1:0] mem_rdata
);
  state_t state, nxt;
  f3_t f3_q;
  logic [31:0] addr_q, wd_q, addr_hold, a_al, ld, st;
  logic acc, bad, mis;
  mem_lane_merge u_merge (
    .word(mem_rdata),
    .wdata(wd_q),
    .ofs(addr_q[1:0]),
    .f3(f3_q),
    .ld(ld),
    .st(st)
  );
  always_comb begin
    acc = state == IDLE && bus.req;
    a_al = bus.funct3[1] ? {bus.addr[31:2], 2'b00}
         : bus.funct3[0] ? {bus.addr[31:1], 1'b0} : bus.addr;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    mis = bus.funct3[1] ? |bus.addr[1:0] : bus.funct3[0] & bus.addr[0];
`else
    mis = 1'b0;
`endif
    bad = bus.addr >= 32'(MEM_WORDS * 4)
       || !(bus.funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
       || (bus.we && bus.funct3[2]) || mis;
    nxt = state == IDLE ? (acc && !bad ? (bus.we ? (bus.funct3 == F3_W ? WRITE : RMW_READ) : LOAD) : IDLE)
        : state == RMW_READ ? WRITE : IDLE;
    bus.ready = state == IDLE;
    mem_addr = state == IDLE ? addr_hold : {addr_q[31:2], 2'b00};
    mem_wren = state == WRITE && !reset;
    mem_wdata = wd_q;
  end
  always_ff @(posedge clk)
    state <= reset ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
      f3_q <= F3_B;
      wd_q <= '0;
      addr_hold <= '0;
      bus.rdata <= '0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.done <= (acc && bad) || state == LOAD || state == WRITE;
      bus.err <= acc && bad;
      if (acc) begin
        addr_q <= a_al;
        f3_q <= bus.funct3;
        wd_q <= bus.wdata;
      end
      if (state != IDLE) addr_hold <= mem_addr;
      if (state == LOAD) bus.rdata <= ld;
      if (state == RMW_READ) wd_q <= st;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit with a 64-word async-read memory model
module tb_mem_access_unit;
  import mem_access_pkg::*;
  typedef struct {
    int cyc;
    logic err;
    logic ld;
    logic [31:0] rd;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pre = 1'b1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_wren;
  logic [31:0] mem [64];
  logic [31:0] last_rd = '0;
  int cyc = 0;
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t e;
  mem_access_if bus();
  mem_access_unit dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wren(mem_wren),
    .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wren) wr_cnt <= wr_cnt + 1;
    if (pre) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h0123_4567;
      mem[4] <= 32'h80F0_7F01;
      mem[5] <= 32'h1122_3344;
      mem[6] <= 32'hCAFE_BABE;
      mem[63] <= 32'h5A00_0000;
    end else if (mem_wren) mem[mem_addr[7:2]] <= mem_wdata;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("mem_addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
    if (!reset && bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 32'h1, 32'h0);
      else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("err", {31'h0, bus.err}, {31'h0, e.err});
        chk("rdata", bus.rdata, e.ld ? e.rd : last_rd);
        if (e.ld) last_rd = e.rd;
      end
    end
  end
  task automatic issue(input logic w, input f3_t f, input logic [31:0] a, input logic [31:0] d,
                       input logic er, input logic ld, input logic [31:0] rd, input int lat,
                       input bit push, output int dc);
    int n = 0;
    while (!bus.ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", 32'h0, 32'h1);
    bus.req = 1'b1;
    bus.we = w;
    bus.funct3 = f;
    bus.addr = a;
    bus.wdata = d;
    dc = cyc;
    if (push) sb.push_back('{cyc + lat, er, ld, rd});
    @(negedge clk);
    bus.req = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 32'h0);
      sb.delete();
    end
  endtask
  initial begin
    int dc, dc_sw, dc_lw, w0;
    bus.req = 1'b0;
    bus.we = 1'b0;
    bus.funct3 = F3_B;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, bus.ready}, 32'h1);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_wren", {31'h0, mem_wren}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;
    pre = 1'b0;
    @(negedge clk);
    issue(0, F3_B, 32'h11, 0, 0, 1, 32'h0000_007F, 2, 1, dc);
    issue(0, F3_B, 32'h13, 0, 0, 1, 32'hFFFF_FF80, 2, 1, dc);
    issue(0, F3_HU, 32'h12, 0, 0, 1, 32'h0000_80F0, 2, 1, dc);
    issue(0, F3_H, 32'h10, 0, 0, 1, 32'h0000_7F01, 2, 1, dc);
    issue(1, F3_B, 32'h16, 32'h0000_00AA, 0, 0, 0, 3, 1, dc);
    drain();
    chk("sb_word5", mem[5], 32'h11AA_3344);
    issue(1, F3_H, 32'h14, 32'h1234_BEEF, 0, 0, 0, 3, 1, dc);
    drain();
    chk("sh_word5", mem[5], 32'h11AA_BEEF);
    issue(1, F3_W, 32'h20, 32'hDEAD_BEEF, 0, 0, 0, 2, 1, dc_sw);
    issue(0, F3_W, 32'h20, 0, 0, 1, 32'hDEAD_BEEF, 2, 1, dc_lw);
    chk("b2b_accept", dc_lw, dc_sw + 2);
    issue(0, F3_BU, 32'h23, 0, 0, 1, 32'h0000_00DE, 2, 1, dc);
    drain();
    w0 = wr_cnt;
    chk("writes_so_far", w0, 3);
    issue(0, F3_W, 32'h100, 0, 1, 0, 0, 1, 1, dc);
    issue(0, 3'b011, 32'h0, 0, 1, 0, 0, 1, 1, dc);
    issue(1, F3_BU, 32'h10, 32'hFF, 1, 0, 0, 1, 1, dc);
    issue(1, F3_W, 32'h100, 32'h5555_5555, 1, 0, 0, 1, 1, dc);
    drain();
    chk("err_no_write", wr_cnt, w0);
    issue(0, F3_BU, 32'hFF, 0, 0, 1, 32'h0000_005A, 2, 1, dc);
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    issue(0, F3_W, 32'h06, 0, 1, 0, 0, 1, 1, dc);
    issue(1, F3_H, 32'h15, 32'h7777, 1, 0, 0, 1, 1, dc);
`else
    issue(0, F3_W, 32'h06, 0, 0, 1, 32'h0123_4567, 2, 1, dc);
    issue(0, F3_HU, 32'h13, 0, 0, 1, 32'h0000_80F0, 2, 1, dc);
`endif
    drain();
    issue(1, F3_B, 32'h18, 32'h77, 0, 0, 0, 3, 0, dc);
    @(negedge clk);
    chk("rmw_write_wren", {31'h0, mem_wren}, 32'h1);
    #2 reset = 1'b1;
    #1 chk("wren_gated", {31'h0, mem_wren}, 32'h0);
    @(negedge clk);
    chk("abort_ready", {31'h0, bus.ready}, 32'h1);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    reset = 1'b0;
    chk("abort_mem6", mem[6], 32'hCAFE_BABE);
    @(negedge clk);
    chk("abort_no_done", {31'h0, bus.done}, 32'h0);
    last_rd = 32'h0;
    issue(0, F3_W, 32'h18, 0, 0, 1, 32'hCAFE_BABE, 2, 1, dc);
    drain();
    chk("total_writes", wr_cnt, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end between the multicycle RISC-V datapath/controller and the unified 64-word instruction/data memory.
- The memory supports only asynchronous word reads and synchronous word writes.
- This block adds byte/halfword loads with sign/zero extension, and byte/halfword stores via a read-modify-write sequence.
- It also checks address range, alignment and access type, and reports completion through a req/ready/done handshake.

Parameters:
- MEM_WORDS, 64, number of 32-bit words in the memory; legal byte addresses are 0 .. MEM_WORDS*4-1.
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  access request; sampled only when ready=1.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RV32I width/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu.
- addr  in  32  byte address.
- wdata  in  32  store data; low byte/half used for sb/sh.
- ready  out  1  block idle and able to accept req.
- done  out  1  one-cycle completion pulse.
- rdata  out  32  extended load result; valid while done=1 and held until the next done.
- err  out  1  qualifies done: the access was rejected.
- mem_addr  out  32  byte address to memory, always word-aligned (low 2 bits = 0).
- mem_wdata  out  32  word written to memory.
- mem_wren  out  1  memory write enable.
- mem_rdata  in  32  asynchronous read data from memory.

Behaviour:
- Reset values: state IDLE; ready=1; done=0; err=0; rdata=0; mem_wren=0; mem_addr=0; mem_wdata=0.
- States: IDLE, LOAD, RMW_READ, WRITE. Request fields (addr, funct3, wdata, we) are registered on acceptance.
- Acceptance occurs when state=IDLE and req=1.
- Error check at acceptance. err is raised if any of:
  - addr >= MEM_WORDS*4;
  - funct3 is not in {000, 001, 010, 100, 101};
  - funct3 is 100 or 101 with we=1;
  - the access is misaligned (see Optional Feature).
- On error: next cycle done=1, err=1, rdata unchanged; no memory write; state stays IDLE.
- Load, latency 2:
  - Cycle 0: accept; go to LOAD.
  - Cycle 1: mem_addr = {addr_q[31:2], 2'b00}; extract byte/half at addr_q[1:0] (half uses addr_q[1]); sign- or zero-extend per funct3; register into rdata; go to IDLE.
  - Cycle 2: done=1.
- Word store, latency 2:
  - Cycle 1 (WRITE): mem_wren=1, mem_wdata=wdata_q; go to IDLE.
  - Cycle 2: done=1.
- Sub-word store, latency 3:
  - Cycle 1 (RMW_READ): capture mem_rdata.
  - Cycle 2 (WRITE): mem_wren=1 with the merged word; only the targeted byte lanes are replaced.
  - Cycle 3: done=1.
- done is exactly one cycle. ready=1 in the done cycle, so back-to-back requests are allowed: a req in the done cycle is accepted.
- req while ready=0 is ignored and not queued.
- mem_wren is high only in WRITE and is gated by !reset, so a reset asserted during WRITE suppresses the write.
- Reset mid-operation: next edge returns to IDLE; no done pulse is produced for the aborted access.
- Outside LOAD, RMW_READ and WRITE, mem_addr holds its last value; mem_wdata is don't-care when mem_wren=0.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_CHECK_EN.
- Defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, is rejected with err=1 and no memory access.
- Undefined: no alignment error is raised. Low bits are forced to alignment: addr[0] cleared for halfword accesses, addr[1:0] cleared for word accesses.

Decomposition:
- Package mem_access_pkg holds:
  - funct3 encodings F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum type;
  - byte-lane mask constants.
- One sub-module, mem_lane_merge: combinational extract/extend for loads and byte-lane merge for stores. The FSM stays in the top module.

Test Plan:
- Preload word 4 = 32'h80F0_7F01; lb @0x11 -> done on cycle 2, rdata=32'h0000007F; lb @0x13 -> 32'hFFFFFF80; lhu @0x12 -> 32'h000080F0.
- sb wdata=32'h000000AA @0x16 onto word 5 = 32'h11223344 -> mem_wren high in cycle 2 only; word 5 becomes 32'h11AA3344; done on cycle 3, err=0.
- sw 32'hDEADBEEF @0x20, then a back-to-back req in the done cycle for lw @0x20 -> accepted; rdata=32'hDEADBEEF.
- addr=0x100 with MEM_WORDS=64, or funct3=011, or lbu with we=1 -> done+err on the next cycle; mem_wren never asserted.
- MEM_ACCESS_MISALIGN_CHECK_EN defined: lw @0x06 -> err=1. Undefined: lw @0x06 -> rdata = word 1 contents, err=0.
- reset asserted in the RMW WRITE cycle -> no memory change, no done; ready=1 on the next cycle.
